// File: rtl/serial_frame_ctrl_if.sv
// Control bundle between serial_frame_ctrl, its counter/shift-register datapath
// and the frame consumer. The controller takes the slave side.
interface serial_frame_ctrl_if;
    logic       start;
    logic       abort;
    logic       rx;
    logic       cnt_co;
    logic       cnt_load;
    logic       cnt_en;
    logic [7:0] cnt_init;
    logic       sr_en;
    logic       sr_in;
    logic       busy;
    logic       done;
    logic       frame_err;

    modport master (
        output start, abort, rx, cnt_co,
        input  cnt_load, cnt_en, cnt_init, sr_en, sr_in, busy, done, frame_err
    );

    modport slave (
        input  start, abort, rx, cnt_co,
        output cnt_load, cnt_en, cnt_init, sr_en, sr_in, busy, done, frame_err
    );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Sequencer for one LSB-first serial frame: drives the external down-counter for
// bit timing and the shift register that captures each data bit at its centre.
module serial_frame_ctrl #(
    parameter int BIT_TICKS = 16
) (
    input logic                  clk,
    input logic                  rst,
    serial_frame_ctrl_if.slave   bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_CENTER = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] FULL_INIT = 8'(BIT_TICKS - 1);
    localparam logic [7:0] HALF_INIT = 8'(BIT_TICKS / 2 - 1);

    logic [2:0] state, state_nx;
    logic [2:0] bit_idx, bit_idx_nx;
    logic       done_q, done_nx;
    logic       frame_err_q, frame_err_nx;
    logic       load, shift;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_nx     = state;
        bit_idx_nx   = bit_idx;
        frame_err_nx = frame_err_q;
        done_nx      = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx     = S_ARM;
                    frame_err_nx = 1'b0;
                end
            end
            S_ARM: begin
                if (!bus.rx) begin
                    load     = 1'b1;
                    state_nx = S_CENTER;
                end
            end
            S_CENTER: begin
                // A line that is high again at mid start bit was a glitch: re-arm silently.
                if (bus.cnt_co) begin
                    if (!bus.rx) begin
                        load       = 1'b1;
                        bit_idx_nx = 3'd0;
                        state_nx   = S_DATA;
                    end else begin
                        state_nx = S_ARM;
                    end
                end
            end
            S_DATA: begin
                if (bus.cnt_co) begin
                    shift      = 1'b1;
                    load       = 1'b1;
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (bus.cnt_co) begin
                    frame_err_nx = ~bus.rx;
                    done_nx      = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Abort overrides whatever the state logic decided this cycle.
        if (bus.abort) begin
            state_nx     = S_IDLE;
            bit_idx_nx   = bit_idx;
            frame_err_nx = frame_err_q;
            done_nx      = 1'b0;
            load         = 1'b0;
            shift        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_idx     <= 3'd0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state       <= state_nx;
            bit_idx     <= bit_idx_nx;
            done_q      <= done_nx;
            frame_err_q <= frame_err_nx;
        end
    end

    // Enable is a pure function of state so cnt_co never loops back into it.
    assign bus.cnt_en    = (state == S_CENTER) || (state == S_DATA) || (state == S_STOP);
    assign bus.cnt_load  = load;
    assign bus.cnt_init  = (state == S_ARM) ? HALF_INIT : FULL_INIT;
    assign bus.sr_en     = shift;
    assign bus.sr_in     = bus.rx;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl with a behavioural down-counter and
// shift register standing in for the datapath.
module tb_serial_frame_ctrl;

    localparam int BT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_ctrl_if bus ();

    serial_frame_ctrl #(.BIT_TICKS(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath stand-ins.
    logic [7:0] cnt_q;
    logic [7:0] sr_q;

    always @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= 8'd0;
        else if (bus.cnt_load) cnt_q <= bus.cnt_init;
        else if (bus.cnt_en)   cnt_q <= cnt_q - 8'd1;
    end

    always @(posedge clk) begin
        if (bus.sr_en) sr_q <= {bus.sr_in, sr_q[7:1]};
    end

    assign bus.cnt_co = bus.cnt_en && (cnt_q == 8'd0);

    // Cycle counter and mid-cycle event monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   sr_cnt = 0;
    int   done_cnt = 0;
    int   idle_cnt = 0;
    int   last_done_cyc = -1;
    logic busy_at_done = 1'bx;
    int   sr_cyc[$];

    always @(negedge clk) begin
        if (bus.sr_en) begin
            sr_cnt++;
            sr_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            last_done_cyc = cyc;
            busy_at_done  = bus.busy;
        end
        if (!bus.busy) idle_cnt++;
    end

    int vectors = 0;
    int miscompares = 0;
    int t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Drive frame cycles c0..c1-1 relative to t; line bit j covers cycles 16j..16j+15.
    task automatic drive(input logic [7:0] data, input logic stop, input int c0, input int c1);
        logic [9:0] line;
        line = {stop, data, 1'b0};
        if (c0 == 0) t = cyc;
        for (int c = c0; c < c1; c++) begin
            bus.rx = (c < 10 * BT) ? line[c / BT] : 1'b1;
            step();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int sr_base, done_base, idle_base;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rx    = 1'b1;

        // Reset state.
        #2;
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_cnt_load",  32'(bus.cnt_load),  32'd0);
        check("rst_cnt_en",    32'(bus.cnt_en),    32'd0);
        check("rst_sr_en",     32'(bus.sr_en),     32'd0);
        check("rst_cnt_init",  32'(bus.cnt_init),  32'd15);
        step();
        step();
        rst = 1'b0;
        idle_cycles(2);

        // Frame 0xA5, valid stop: shift and done timing.
        do_start();
        idle_cycles(2);
        check("arm_cnt_init", 32'(bus.cnt_init), 32'd7);
        sr_base   = sr_cnt;
        done_base = done_cnt;
        drive(8'hA5, 1'b1, 0, 10 * BT);
        bus.rx = 1'b1;
        check("a5_sr_count", 32'(sr_cnt - sr_base), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("a5_sr_cyc%0d", k), 32'(sr_cyc[sr_base + k]), 32'(t + 24 + 16 * k));
        check("a5_done_count", 32'(done_cnt - done_base), 32'd1);
        check("a5_done_cyc",   32'(last_done_cyc),        32'(t + 153));
        check("a5_busy_done",  32'(busy_at_done),         32'd0);
        check("a5_data",       32'(sr_q),                 32'h000000A5);
        check("a5_frame_err",  32'(bus.frame_err),        32'd0);

        // Frame 0x3C with stop bit low, then start clears frame_err.
        do_start();
        done_base = done_cnt;
        drive(8'h3C, 1'b0, 0, 10 * BT);
        bus.rx = 1'b1;
        idle_cycles(3);
        check("3c_data",       32'(sr_q),                 32'h0000003C);
        check("3c_done_count", 32'(done_cnt - done_base), 32'd1);
        check("3c_frame_err",  32'(bus.frame_err),        32'd1);
        do_start();
        check("3c_err_cleared", 32'(bus.frame_err), 32'd0);
        check("3c_rearm_busy",  32'(bus.busy),      32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_idle_busy", 32'(bus.busy), 32'd0);

        // Start-bit glitch of 3 cycles: rejected at t+8, back in ARM.
        do_start();
        sr_base = sr_cnt;
        t = cyc;
        bus.rx = 1'b0;
        idle_cycles(3);
        bus.rx = 1'b1;
        idle_cycles(5);
        at_neg();
        check("gl_cyc",      32'(cyc),          32'(t + 8));
        check("gl_cnt_co",   32'(bus.cnt_co),   32'd1);
        check("gl_cnt_load", 32'(bus.cnt_load), 32'd0);
        step();
        check("gl_arm_en",   32'(bus.cnt_en),   32'd0);
        check("gl_arm_init", 32'(bus.cnt_init), 32'd7);
        idle_cycles(20);
        check("gl_busy",     32'(bus.busy),          32'd1);
        check("gl_no_shift", 32'(sr_cnt - sr_base),  32'd0);
        done_base = done_cnt;
        drive(8'h01, 1'b1, 0, 10 * BT);
        bus.rx = 1'b1;
        check("01_data",       32'(sr_q),                 32'h00000001);
        check("01_done_count", 32'(done_cnt - done_base), 32'd1);

        // Asynchronous reset mid-DATA after four shifts.
        do_start();
        sr_base   = sr_cnt;
        done_base = done_cnt;
        drive(8'h5A, 1'b1, 0, 80);
        check("rd_sr_count", 32'(sr_cnt - sr_base), 32'd4);
        check("rd_busy_pre", 32'(bus.busy),         32'd1);
        rst = 1'b1;
        #1;
        check("rd_busy",     32'(bus.busy),     32'd0);
        check("rd_cnt_en",   32'(bus.cnt_en),   32'd0);
        check("rd_cnt_load", 32'(bus.cnt_load), 32'd0);
        check("rd_sr_en",    32'(bus.sr_en),    32'd0);
        check("rd_cnt_init", 32'(bus.cnt_init), 32'd15);
        check("rd_done",     32'(bus.done),     32'd0);
        step();
        rst = 1'b0;
        bus.rx = 1'b1;
        idle_cycles(100);
        check("rd_no_done", 32'(done_cnt - done_base), 32'd0);
        done_base = done_cnt;
        do_start();
        drive(8'hFF, 1'b1, 0, 10 * BT);
        bus.rx = 1'b1;
        check("ff_data",       32'(sr_q),                 32'h000000FF);
        check("ff_done_count", 32'(done_cnt - done_base), 32'd1);
        check("ff_frame_err",  32'(bus.frame_err),        32'd0);

        // Abort coincident with the third data-bit cnt_co.
        do_start();
        sr_base   = sr_cnt;
        done_base = done_cnt;
        drive(8'h6B, 1'b1, 0, 56);
        bus.abort = 1'b1;
        at_neg();
        check("ab_cnt_co",   32'(bus.cnt_co),   32'd1);
        check("ab_sr_en",    32'(bus.sr_en),    32'd0);
        check("ab_cnt_load", 32'(bus.cnt_load), 32'd0);
        step();
        bus.abort = 1'b0;
        check("ab_busy",   32'(bus.busy),   32'd0);
        check("ab_cnt_en", 32'(bus.cnt_en), 32'd0);
        bus.rx = 1'b1;
        idle_cycles(120);
        check("ab_no_done",  32'(done_cnt - done_base), 32'd0);
        check("ab_sr_count", 32'(sr_cnt - sr_base),     32'd2);

        // Start pulsed mid-frame (ignored) and held through done (re-arms).
        do_start();
        done_base = done_cnt;
        idle_base = idle_cnt;
        drive(8'h96, 1'b1, 0, 40);
        bus.start = 1'b1;
        drive(8'h96, 1'b1, 40, 41);
        bus.start = 1'b0;
        drive(8'h96, 1'b1, 41, 150);
        bus.start = 1'b1;
        drive(8'h96, 1'b1, 150, 170);
        check("hs_data",       32'(sr_q),                 32'h00000096);
        check("hs_done_count", 32'(done_cnt - done_base), 32'd1);
        check("hs_done_cyc",   32'(last_done_cyc),        32'(t + 153));
        check("hs_busy_done",  32'(busy_at_done),         32'd0);
        check("hs_idle_once",  32'(idle_cnt - idle_base), 32'd1);
        check("hs_rearmed",    32'(bus.busy),             32'd1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("hs_final_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
